// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: round-robin arbiter for reg_file's write port with a pending-write scoreboard.
// Define REG_WB_FWD_EN to add same-cycle forwarding from the granted writeback (fwd1_data/fwd2_data).
module reg_wb_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic              wb0_valid,
  input  logic [ADDR_W-1:0] wb0_addr,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [ADDR_W-1:0] wb1_addr,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              hazard1,
  output logic              hazard2
`ifdef REG_WB_FWD_EN
  ,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
`endif
);
  localparam int N = 2**ADDR_W;
  localparam logic [N-1:0] NZ_MASK = {{(N-1){1'b1}}, 1'b0};
  logic [N-1:0] pend_q, pend_d;
  logic last_grant, g0, g1, gv, gnz;
  logic [ADDR_W-1:0] ga;
  logic [DATA_W-1:0] gd;
  // last_grant=1 means wb1 won last, so wb0 wins the next contention
  assign g0 = wb0_valid && (!wb1_valid || last_grant);
  assign g1 = wb1_valid && !g0;
  assign gv = g0 || g1;
  assign ga = g0 ? wb0_addr : wb1_addr;
  assign gd = g0 ? wb0_data : wb1_data;
  assign gnz = gv && (ga != '0);
  assign wb0_ready = g0;
  assign wb1_ready = g1;
  assign issue_ready = issue_valid && ((issue_addr == '0) || !pend_q[issue_addr]);
`ifdef REG_WB_FWD_EN
  logic hit1, hit2;
  assign hit1 = gnz && (ga == ra1);
  assign hit2 = gnz && (ga == ra2);
  assign hazard1 = pend_q[ra1] && !hit1;
  assign hazard2 = pend_q[ra2] && !hit2;
  assign fwd1_data = hit1 ? gd : '0;
  assign fwd2_data = hit2 ? gd : '0;
`else
  assign hazard1 = pend_q[ra1];
  assign hazard2 = pend_q[ra2];
`endif
  // set after clear so a same-cycle reservation of the retiring register survives
  always_comb begin
    pend_d = pend_q;
    if (gv) pend_d[ga] = 1'b0;
    if (issue_ready) pend_d[issue_addr] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we <= 1'b0;
      rf_wa <= '0;
      rf_wd <= '0;
      pend_q <= '0;
      last_grant <= 1'b1;
    end else begin
      rf_we <= gnz;
      if (gnz) begin
        rf_wa <= ga;
        rf_wd <= gd;
      end
      if (gv) last_grant <= g1;
      pend_q <= pend_d & NZ_MASK;
    end
  end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_reg_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic issue_valid, issue_ready, wb0_valid, wb0_ready, wb1_valid, wb1_ready, rf_we, hazard1, hazard2;
  logic [4:0] issue_addr, wb0_addr, wb1_addr, rf_wa, ra1, ra2;
  logic [31:0] wb0_data, wb1_data, rf_wd;
`ifdef REG_WB_FWD_EN
  logic [31:0] fwd1_data, fwd2_data;
`endif
  int checks = 0;
  int failures = 0;
  bit mp[32];
  int mlast;
  logic m_we;
  logic [4:0] m_wa;
  logic [31:0] m_wd;

  reg_wb_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .wb0_valid(wb0_valid), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .ra1(ra1), .ra2(ra2), .hazard1(hazard1), .hazard2(hazard2)
`ifdef REG_WB_FWD_EN
    , .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );

  always #5 clk = ~clk;

  function automatic bit exp_g0();
    if (!wb0_valid) return 1'b0;
    if (!wb1_valid) return 1'b1;
    return mlast == 1;
  endfunction

  function automatic bit exp_g1();
    return wb1_valid && !exp_g0();
  endfunction

  function automatic bit exp_ir();
    return issue_valid && (issue_addr == 5'd0 || !mp[issue_addr]);
  endfunction

  function automatic logic [4:0] gaddr();
    return exp_g0() ? wb0_addr : wb1_addr;
  endfunction

  function automatic logic [31:0] gdata();
    return exp_g0() ? wb0_data : wb1_data;
  endfunction

  function automatic bit fwd_hit(input logic [4:0] a);
`ifdef REG_WB_FWD_EN
    return (exp_g0() || exp_g1()) && gaddr() != 5'd0 && gaddr() == a;
`else
    return a != a;
`endif
  endfunction

  function automatic bit exp_haz(input logic [4:0] a);
    return a != 5'd0 && mp[a] && !fwd_hit(a);
  endfunction

  function automatic logic [31:0] exp_fwd(input logic [4:0] a);
    return fwd_hit(a) ? gdata() : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mp[i] = 1'b0;
    mlast = 1;
    m_we = 1'b0;
    m_wa = '0;
    m_wd = '0;
  endtask

  task automatic idle();
    issue_valid = 0; issue_addr = 0;
    wb0_valid = 0; wb0_addr = 0; wb0_data = 0;
    wb1_valid = 0; wb1_addr = 0; wb1_data = 0;
    ra1 = 0; ra2 = 0;
  endtask

  // advances one clock and moves the model across the same edge
  task automatic tick();
    bit g0 = exp_g0();
    bit g1 = exp_g1();
    bit ir = exp_ir();
    logic [4:0] a = gaddr();
    logic [31:0] d = gdata();
    logic [4:0] ia = issue_addr;
    @(posedge clk);
    m_we = (g0 || g1) && a != 5'd0;
    if (m_we) begin
      m_wa = a;
      m_wd = d;
    end
    if (g0 || g1) begin
      mp[a] = 1'b0;
      mlast = g1 ? 1 : 0;
    end
    if (ir && ia != 5'd0) mp[ia] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
    checks++; if (rf_wa !== 5'd0) begin failures++; $display("FAIL reset_rf_wa got=%0d exp=0", rf_wa); end
    checks++; if (rf_wd !== 32'd0) begin failures++; $display("FAIL reset_rf_wd got=%0h exp=0", rf_wd); end
    issue_valid = 1; issue_addr = 5;
    wb0_valid = 1; wb0_addr = 5; wb0_data = 32'h5555;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin failures++; $display("FAIL midreset_grant got=%0b exp=1", wb0_ready); end
    rst = 1'b0;
    model_reset();
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midreset_rf_we got=%0b exp=0", rf_we); end
    @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    ra1 = 5;
    #1;
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL midreset_haz5 got=%0b exp=0", hazard1); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL midreset_no_replay got=%0b exp=0", rf_we); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      #1;
      checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("FAIL reset_pending_clear addr=%0d got=%0b%0b exp=00", i, hazard1, hazard2); end
    end
    idle();
  endtask

  task automatic test_contention();
    idle();
    wb0_valid = 1; wb0_addr = 3; wb0_data = 32'h11;
    wb1_valid = 1; wb1_addr = 4; wb1_data = 32'h22;
    #1;
    checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin failures++; $display("FAIL contention_c1 got=%0b%0b exp=10", wb0_ready, wb1_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd3 || rf_wd !== 32'h11) begin failures++; $display("FAIL contention_commit0 got=%0b/%0d/%0h exp=1/3/11", rf_we, rf_wa, rf_wd); end
    checks++; if (wb0_ready !== 1'b0 || wb1_ready !== 1'b1) begin failures++; $display("FAIL contention_c2 got=%0b%0b exp=01", wb0_ready, wb1_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd4 || rf_wd !== 32'h22) begin failures++; $display("FAIL contention_commit1 got=%0b/%0d/%0h exp=1/4/22", rf_we, rf_wa, rf_wd); end
    checks++; if (wb0_ready !== 1'b1 || wb1_ready !== 1'b0) begin failures++; $display("FAIL contention_c3 got=%0b%0b exp=10", wb0_ready, wb1_ready); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (wb0_ready !== exp_g0() || wb1_ready !== exp_g1()) begin failures++; $display("FAIL contention_alt i=%0d got=%0b%0b exp=%0b%0b", i, wb0_ready, wb1_ready, exp_g0(), exp_g1()); end
      tick();
    end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_valid = 1; issue_addr = 7;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL sb_issue7 got=%0b exp=1", issue_ready); end
    tick();
    issue_valid = 0; ra1 = 7;
    #1;
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL sb_haz7 got=%0b exp=1", hazard1); end
    issue_valid = 1;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sb_waw_stall got=%0b exp=0", issue_ready); end
    issue_valid = 0;
    wb1_valid = 1; wb1_addr = 7; wb1_data = 32'h77;
    #1;
    checks++; if (wb1_ready !== 1'b1) begin failures++; $display("FAIL sb_wb1_grant got=%0b exp=1", wb1_ready); end
    checks++; if (hazard1 !== exp_haz(5'd7)) begin failures++; $display("FAIL sb_haz_grant got=%0b exp=%0b", hazard1, exp_haz(5'd7)); end
    tick();
    wb1_valid = 0;
    #1;
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL sb_haz_cleared got=%0b exp=0", hazard1); end
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd7 || rf_wd !== 32'h77) begin failures++; $display("FAIL sb_commit got=%0b/%0d/%0h exp=1/7/77", rf_we, rf_wa, rf_wd); end
    idle();
  endtask

  task automatic test_same_cycle();
    idle();
    wb0_valid = 1; wb0_addr = 9; wb0_data = 32'h99;
    issue_valid = 1; issue_addr = 9;
    #1;
    checks++; if (issue_ready !== 1'b1 || wb0_ready !== 1'b1) begin failures++; $display("FAIL same_handshake got=%0b%0b exp=11", issue_ready, wb0_ready); end
    tick();
    idle();
    ra1 = 9;
    #1;
    checks++; if (rf_we !== 1'b1 || rf_wa !== 5'd9 || rf_wd !== 32'h99) begin failures++; $display("FAIL same_commit got=%0b/%0d/%0h exp=1/9/99", rf_we, rf_wa, rf_wd); end
    checks++; if (hazard1 !== 1'b1) begin failures++; $display("FAIL same_set_wins got=%0b exp=1", hazard1); end
    issue_valid = 1; issue_addr = 9;
    wb0_valid = 1; wb0_addr = 9; wb0_data = 32'h9A;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL same_pending_stall got=%0b exp=0", issue_ready); end
    tick();
    idle();
    ra1 = 9;
    #1;
    checks++; if (hazard1 !== 1'b0) begin failures++; $display("FAIL same_cleared got=%0b exp=0", hazard1); end
    checks++; if (rf_wa !== 5'd9 || rf_wd !== 32'h9A) begin failures++; $display("FAIL same_commit2 got=%0d/%0h exp=9/9a", rf_wa, rf_wd); end
    idle();
  endtask

  task automatic test_x0();
    idle();
    wb0_valid = 1; wb0_addr = 0; wb0_data = 32'hDEAD;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin failures++; $display("FAIL x0_ready got=%0b exp=1", wb0_ready); end
    tick();
    idle();
    #1;
    checks++; if (rf_we !== 1'b0 || rf_wa !== 5'd9 || rf_wd !== 32'h9A) begin failures++; $display("FAIL x0_no_write got=%0b/%0d/%0h exp=0/9/9a", rf_we, rf_wa, rf_wd); end
    issue_valid = 1; issue_addr = 0;
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL x0_issue got=%0b exp=1", issue_ready); end
    tick();
    idle();
    #1;
    checks++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0) begin failures++; $display("FAIL x0_hazard got=%0b%0b exp=00", hazard1, hazard2); end
  endtask

  task automatic test_fwd();
    idle();
    issue_valid = 1; issue_addr = 2;
    tick();
    idle();
    ra2 = 2;
    wb0_valid = 1; wb0_addr = 2; wb0_data = 32'h55;
    #1;
    checks++; if (wb0_ready !== 1'b1) begin failures++; $display("FAIL fwd_grant got=%0b exp=1", wb0_ready); end
`ifdef REG_WB_FWD_EN
    checks++; if (hazard2 !== 1'b0 || fwd2_data !== 32'h55) begin failures++; $display("FAIL fwd_hit got=%0b/%0h exp=0/55", hazard2, fwd2_data); end
    checks++; if (fwd1_data !== 32'd0) begin failures++; $display("FAIL fwd_miss got=%0h exp=0", fwd1_data); end
`else
    checks++; if (hazard2 !== 1'b1) begin failures++; $display("FAIL nofwd_haz got=%0b exp=1", hazard2); end
`endif
    tick();
    idle();
    ra2 = 2;
    #1;
    checks++; if (hazard2 !== 1'b0) begin failures++; $display("FAIL fwd_after got=%0b exp=0", hazard2); end
    idle();
  endtask

  task automatic test_random();
    bit p0 = 1'b1;
    bit p1 = 1'b1;
    idle();
    for (int n = 0; n < 600; n++) begin
      if (p0 || !wb0_valid) begin
        wb0_valid = ($urandom_range(0, 9) < 6);
        wb0_addr = 5'($urandom_range(0, 7));
        wb0_data = $urandom;
      end
      if (p1 || !wb1_valid) begin
        wb1_valid = ($urandom_range(0, 9) < 6);
        wb1_addr = 5'($urandom_range(0, 7));
        wb1_data = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_addr = 5'($urandom_range(0, 7));
      ra1 = 5'($urandom_range(0, 7));
      ra2 = 5'($urandom_range(0, 7));
      #1;
      checks++; if (wb0_ready !== exp_g0() || wb1_ready !== exp_g1()) begin failures++; $display("FAIL rnd_grant n=%0d got=%0b%0b exp=%0b%0b", n, wb0_ready, wb1_ready, exp_g0(), exp_g1()); end
      checks++; if (issue_ready !== exp_ir()) begin failures++; $display("FAIL rnd_issue n=%0d got=%0b exp=%0b", n, issue_ready, exp_ir()); end
      checks++; if (hazard1 !== exp_haz(ra1) || hazard2 !== exp_haz(ra2)) begin failures++; $display("FAIL rnd_hazard n=%0d got=%0b%0b exp=%0b%0b", n, hazard1, hazard2, exp_haz(ra1), exp_haz(ra2)); end
`ifdef REG_WB_FWD_EN
      checks++; if (fwd1_data !== exp_fwd(ra1) || fwd2_data !== exp_fwd(ra2)) begin failures++; $display("FAIL rnd_fwd n=%0d got=%0h/%0h exp=%0h/%0h", n, fwd1_data, fwd2_data, exp_fwd(ra1), exp_fwd(ra2)); end
`endif
      p0 = exp_g0();
      p1 = exp_g1();
      tick();
      checks++; if (rf_we !== m_we || rf_wa !== m_wa || rf_wd !== m_wd) begin failures++; $display("FAIL rnd_commit n=%0d got=%0b/%0d/%0h exp=%0b/%0d/%0h", n, rf_we, rf_wa, rf_wd, m_we, m_wa, m_wd); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_contention();
    test_scoreboard();
    test_same_cycle();
    test_x0();
    test_fwd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
